priority_encode_serial: RTL and testbench

PRIORITY_ENCODE_SERIAL -- requirements
Module: priority_encode_serial

---
 rtl/priority_encode_serial.sv | 90 +++++++++
 tb/tb_priority_encode_serial.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encode_serial.sv
// Serialises an 8-bit request vector into one binary code per set bit.
// PRIORITY_HIGH selects whether the lowest or the highest set index goes out first.
module priority_encode_serial #(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       a_valid,
  output logic       a_ready,
  output logic [2:0] y,
  output logic       y_valid,
  input  logic       y_ready,
  output logic       last,
  output logic [3:0] count,
  output logic       err
);

  typedef enum logic {IDLE, SERIAL} state_t;

  state_t     state, state_next;
  logic [7:0] pending, pending_next;
  logic       err_next;
  logic [2:0] sel;
  logic [3:0] ones;
  logic       accept, pop;

  // Later loop iterations win, so the scan direction decides the priority.
  always_comb begin
    sel = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (pending[i]) sel = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending[i]) sel = 3'(i);
      end
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + 4'(pending[i]);
    end
  end

  assign y_valid = (state == SERIAL);
  assign y       = y_valid ? sel : 3'b000;
  assign count   = y_valid ? ones : 4'd0;
  assign last    = y_valid && (ones == 4'd1);
  // Only combinational input-to-output path: a new vector may enter on the final pop.
  assign a_ready = (state == IDLE) || (last && y_ready);
  assign accept  = a_valid && a_ready;
  assign pop     = y_valid && y_ready;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    err_next     = 1'b0;
    if (pop) begin
      pending_next = pending & ~(8'b0000_0001 << sel);
      if (last) state_next = IDLE;
    end
    if (accept) begin
      if (a != 8'h00) begin
        pending_next = a;
        state_next   = SERIAL;
      end else begin
        pending_next = 8'h00;
        state_next   = IDLE;
        err_next     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'h00;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      err     <= err_next;
    end
  end

endmodule

// File: tb/tb_priority_encode_serial.sv
// Scoreboard bench: both priority orders run side by side on shared stimulus,
// expected code streams come from a set-bit list per accepted vector.
module tb_priority_encode_serial;

  typedef struct {
    logic       is_err;
    logic [2:0] code;
    logic [3:0] cnt;
    logic       lst;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic       a_valid = 1'b0;
  logic       y_ready = 1'b0;

  logic       a_ready_lo, y_valid_lo, last_lo, err_lo;
  logic [2:0] y_lo;
  logic [3:0] count_lo;
  logic       a_ready_hi, y_valid_hi, last_hi, err_hi;
  logic [2:0] y_hi;
  logic [3:0] count_hi;

  int checks = 0;
  int failures = 0;

  entry_t q_lo[$];
  entry_t q_hi[$];

  int         remaining = 0;
  logic       prev_accept = 1'b0;
  logic [7:0] prev_a = 8'h00;
  logic       prev_y_ready = 1'b0;

  priority_encode_serial #(.PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid), .a_ready(a_ready_lo),
    .y(y_lo), .y_valid(y_valid_lo), .y_ready(y_ready), .last(last_lo),
    .count(count_lo), .err(err_lo)
  );

  priority_encode_serial #(.PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid), .a_ready(a_ready_hi),
    .y(y_hi), .y_valid(y_valid_hi), .y_ready(y_ready), .last(last_hi),
    .count(count_hi), .err(err_hi)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every set bit becomes one code; the remaining count shrinks by one per code.
  task automatic push_vector(input logic [7:0] v);
    entry_t e;
    int n, k;
    if (v == 8'h00) begin
      e = '{is_err: 1'b1, code: 3'd0, cnt: 4'd0, lst: 1'b0};
      q_lo.push_back(e);
      q_hi.push_back(e);
    end else begin
      n = $countones(v);
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          e = '{is_err: 1'b0, code: 3'(i), cnt: 4'(n - k), lst: (k == n - 1)};
          q_lo.push_back(e);
          k++;
        end
      end
      k = 0;
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin
          e = '{is_err: 1'b0, code: 3'(i), cnt: 4'(n - k), lst: (k == n - 1)};
          q_hi.push_back(e);
          k++;
        end
      end
    end
  endtask

  // One clock of stimulus; the model tracks how many codes the DUT still owes.
  task automatic apply_stimulus(input logic [7:0] av, input logic avld, input logic yr);
    logic exp_ready;
    @(negedge clk);
    if (remaining > 0 && prev_y_ready) remaining--;
    if (prev_accept) remaining = $countones(prev_a);
    check_output("y_valid_lo", int'(y_valid_lo), int'(remaining > 0));
    check_output("y_valid_hi", int'(y_valid_hi), int'(remaining > 0));
    a       = av;
    a_valid = avld;
    y_ready = yr;
    exp_ready = (remaining == 0) || (remaining == 1 && yr);
    #1;
    check_output("a_ready_lo", int'(a_ready_lo), int'(exp_ready));
    check_output("a_ready_hi", int'(a_ready_hi), int'(exp_ready));
    prev_accept  = avld && exp_ready;
    prev_a       = av;
    prev_y_ready = yr;
    if (prev_accept) push_vector(av);
  endtask

  task automatic reset_mid;
    #3;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    y_ready = 1'b0;
    #1;
    check_output("rst_y_valid_lo", int'(y_valid_lo), 0);
    check_output("rst_y_valid_hi", int'(y_valid_hi), 0);
    check_output("rst_count_lo", int'(count_lo), 0);
    check_output("rst_count_hi", int'(count_hi), 0);
    q_lo.delete();
    q_hi.delete();
    remaining    = 0;
    prev_accept  = 1'b0;
    prev_y_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic compare_code(input string tag, input entry_t e, input logic [2:0] yv,
                              input logic [3:0] cv, input logic lv);
    check_output({tag, "_y"}, int'(yv), int'(e.code));
    check_output({tag, "_count"}, int'(cv), int'(e.cnt));
    check_output({tag, "_last"}, int'(lv), int'(e.lst));
  endtask

  // Monitor: codes are checked every valid cycle (stability) and consumed on a pop.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (err_lo) begin
          check_output("err_lo_expected", int'(q_lo.size() > 0 && q_lo[0].is_err), 1);
          if (q_lo.size() > 0 && q_lo[0].is_err) void'(q_lo.pop_front());
        end else if (y_valid_lo) begin
          if (q_lo.size() == 0 || q_lo[0].is_err) begin
            check_output("code_lo_expected", 0, 1);
          end else begin
            compare_code("lo", q_lo[0], y_lo, count_lo, last_lo);
            if (y_ready) void'(q_lo.pop_front());
          end
        end
        if (err_hi) begin
          check_output("err_hi_expected", int'(q_hi.size() > 0 && q_hi[0].is_err), 1);
          if (q_hi.size() > 0 && q_hi[0].is_err) void'(q_hi.pop_front());
        end else if (y_valid_hi) begin
          if (q_hi.size() == 0 || q_hi[0].is_err) begin
            check_output("code_hi_expected", 0, 1);
          end else begin
            compare_code("hi", q_hi[0], y_hi, count_hi, last_hi);
            if (y_ready) void'(q_hi.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] av;
    #3;
    check_output("reset_y_valid", int'(y_valid_lo), 0);
    check_output("reset_y", int'(y_lo), 0);
    check_output("reset_count", int'(count_lo), 0);
    check_output("reset_last", int'(last_lo), 0);
    check_output("reset_err", int'(err_lo), 0);
    check_output("reset_y_valid_hi", int'(y_valid_hi), 0);
    #10;
    rst_n = 1'b1;
    #1;
    check_output("post_reset_a_ready", int'(a_ready_lo), 1);

    // Single bit, then multi-bit with the consumer always ready.
    apply_stimulus(8'b0000_0100, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    apply_stimulus(8'b1001_0010, 1'b1, 1'b1);
    repeat (4) apply_stimulus(8'h55, 1'b0, 1'b1);

    // Backpressure holds the first code stable.
    apply_stimulus(8'b0000_0011, 1'b1, 1'b0);
    repeat (3) apply_stimulus(8'hff, 1'b0, 1'b0);
    repeat (3) apply_stimulus(8'h00, 1'b0, 1'b1);

    // Zero vector, then back-to-back on the last beat, then last pop with a zero vector.
    apply_stimulus(8'h00, 1'b1, 1'b0);
    repeat (2) apply_stimulus(8'h00, 1'b0, 1'b0);
    apply_stimulus(8'b1000_0000, 1'b1, 1'b1);
    apply_stimulus(8'b0100_0000, 1'b1, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'b0000_0001, 1'b1, 1'b1);
    apply_stimulus(8'h00, 1'b1, 1'b1);
    repeat (2) apply_stimulus(8'h00, 1'b0, 1'b1);

    // Reset while three codes are pending; nothing may appear afterwards.
    apply_stimulus(8'b1001_0010, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    reset_mid();
    repeat (4) apply_stimulus(8'hff, 1'b0, 1'b1);

    for (int i = 0; i < 800; i++) begin
      av = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) av = 8'h00;
      apply_stimulus(av, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
      if (i == 400) reset_mid();
    end

    repeat (12) apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("drain_lo", q_lo.size(), 0);
    check_output("drain_hi", q_hi.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
